// File: rtl/heap_pkg.sv
// Shared opcodes, status codes, FSM states and the key-ordering predicate for heap_pq.
package heap_pkg;

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpPush = 2'b01;
    localparam logic [1:0] OpPop  = 2'b10;
    localparam logic [1:0] OpRepl = 2'b11;

    localparam logic [1:0] StatOk    = 2'b00;
    localparam logic [1:0] StatEmpty = 2'b01;
    localparam logic [1:0] StatFull  = 2'b10;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSiftUp   = 2'd1;
    localparam logic [1:0] StSiftDown = 2'd2;
    localparam logic [1:0] StDone     = 2'd3;

    localparam logic [1:0] SelSelf = 2'd0;
    localparam logic [1:0] SelL    = 2'd1;
    localparam logic [1:0] SelR    = 2'd2;

    // Keys are zero-extended to this width before comparison, so KEY_W must not exceed it.
    localparam int unsigned KeyWMax = 64;

    // Strict ordering: equal keys are never "better", so they never swap.
    function automatic logic better(input logic [KeyWMax-1:0] a,
                                    input logic [KeyWMax-1:0] b,
                                    input logic               min_heap);
        return min_heap ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/heap_node_sel.sv
// Best-of-three selector for a heap node and its two children; ties favour self, then left.
module heap_node_sel
    import heap_pkg::*;
#(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned MIN_HEAP = 0
) (
    input  logic [KEY_W-1:0] self_key_i,
    input  logic [KEY_W-1:0] l_key_i,
    input  logic [KEY_W-1:0] r_key_i,
    input  logic             l_valid_i,
    input  logic             r_valid_i,
    output logic [1:0]       sel_o
);

    localparam logic MinH = (MIN_HEAP != 0);

    logic [KEY_W-1:0] best_key;

    always_comb begin
        sel_o    = SelSelf;
        best_key = self_key_i;
        if (l_valid_i && better(KeyWMax'(l_key_i), KeyWMax'(best_key), MinH)) begin
            sel_o    = SelL;
            best_key = l_key_i;
        end
        if (r_valid_i && better(KeyWMax'(r_key_i), KeyWMax'(best_key), MinH)) begin
            sel_o = SelR;
        end
    end

endmodule

// File: rtl/heap_pq.sv
// Parametrised binary-heap priority queue with push/pop/replace commands and one response
// per accepted command; sifting proceeds one heap level per clock.
module heap_pq
    import heap_pkg::*;
#(
    parameter int unsigned KEY_W      = 32,
    parameter int unsigned PLD_W      = 8,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned MIN_HEAP   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [KEY_W-1:0]      cmd_key_i,
    input  logic [PLD_W-1:0]      cmd_pld_i,
    output logic                  rsp_valid_o,
    output logic [1:0]            rsp_status_o,
    output logic [KEY_W-1:0]      rsp_key_o,
    output logic [PLD_W-1:0]      rsp_pld_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  top_valid_o,
    output logic [KEY_W-1:0]      top_key_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;
    localparam int unsigned IdxW  = DEPTH_LOG2;
    localparam logic        MinH  = (MIN_HEAP != 0);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [KEY_W-1:0] rsp_key_q, rsp_key_d;
    logic [PLD_W-1:0] rsp_pld_q, rsp_pld_d;

    logic [KEY_W-1:0] key_q [Depth];
    logic [PLD_W-1:0] pld_q [Depth];

    logic            accept, empty, full;
    logic [IdxW-1:0] push_idx, last_idx, parent_idx;
    logic            up_swap, down_swap;

    // idx_q always addresses a live entry, so it fits in IdxW bits; the child indices get
    // extra headroom so 2*idx+2 never wraps back into range.
    logic [IdxW:0]   l_ext;
    logic [IdxW+1:0] r_ext;
    logic            l_valid, r_valid;
    logic [IdxW-1:0] l_idx, r_idx, best_idx;
    logic [1:0]      sel;

    assign accept   = cmd_valid_i && (state_q == StIdle);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(Depth));
    assign push_idx = IdxW'(count_q);
    assign last_idx = IdxW'(count_q - CntW'(1));

    assign parent_idx = (idx_q - IdxW'(1)) >> 1;
    assign up_swap    = (idx_q != '0) &&
                        better(KeyWMax'(key_q[idx_q]), KeyWMax'(key_q[parent_idx]), MinH);

    assign l_ext   = {idx_q, 1'b1};
    assign r_ext   = {1'b0, l_ext} + (IdxW + 2)'(1);
    assign l_valid = (l_ext < count_q);
    assign r_valid = (r_ext < {1'b0, count_q});
    assign l_idx   = l_ext[IdxW-1:0];
    assign r_idx   = r_ext[IdxW-1:0];

    heap_node_sel #(
        .KEY_W    (KEY_W),
        .MIN_HEAP (MIN_HEAP)
    ) u_node_sel (
        .self_key_i (key_q[idx_q]),
        .l_key_i    (key_q[l_idx]),
        .r_key_i    (key_q[r_idx]),
        .l_valid_i  (l_valid),
        .r_valid_i  (r_valid),
        .sel_o      (sel)
    );

    assign down_swap = (sel != SelSelf);
    assign best_idx  = (sel == SelL) ? l_idx : ((sel == SelR) ? r_idx : idx_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        rsp_status_d = rsp_status_q;
        rsp_key_d    = rsp_key_q;
        rsp_pld_d    = rsp_pld_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    rsp_status_d = StatOk;
                    rsp_key_d    = '0;
                    rsp_pld_d    = '0;
                    state_d      = StDone;
                    case (cmd_op_i)
                        OpPush: begin
                            if (full) begin
                                rsp_status_d = StatFull;
                            end else begin
                                count_d = count_q + CntW'(1);
                                idx_d   = push_idx;
                                state_d = StSiftUp;
                            end
                        end
                        OpPop: begin
                            if (empty) begin
                                rsp_status_d = StatEmpty;
                            end else begin
                                rsp_key_d = key_q[0];
                                rsp_pld_d = pld_q[0];
                                count_d   = count_q - CntW'(1);
                                idx_d     = '0;
                                state_d   = StSiftDown;
                            end
                        end
                        OpRepl: begin
                            idx_d = '0;
                            if (empty) begin
                                // Replace on an empty queue degenerates to a push at the root.
                                rsp_status_d = StatEmpty;
                                count_d      = CntW'(1);
                                state_d      = StSiftUp;
                            end else begin
                                rsp_key_d = key_q[0];
                                rsp_pld_d = pld_q[0];
                                state_d   = StSiftDown;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StSiftUp: begin
                if (up_swap) idx_d = parent_idx;
                else         state_d = StDone;
            end
            StSiftDown: begin
                if (down_swap) idx_d = best_idx;
                else           state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            count_q      <= '0;
            idx_q        <= '0;
            rsp_status_q <= StatOk;
            rsp_key_q    <= '0;
            rsp_pld_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            rsp_status_q <= rsp_status_d;
            rsp_key_q    <= rsp_key_d;
            rsp_pld_q    <= rsp_pld_d;
        end
    end

    // Entry storage is deliberately unreset; slots at or beyond count_q are never consumed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            case (cmd_op_i)
                OpPush: begin
                    if (!full) begin
                        key_q[push_idx] <= cmd_key_i;
                        pld_q[push_idx] <= cmd_pld_i;
                    end
                end
                OpPop: begin
                    if (!empty) begin
                        key_q[0] <= key_q[last_idx];
                        pld_q[0] <= pld_q[last_idx];
                    end
                end
                OpRepl: begin
                    key_q[0] <= cmd_key_i;
                    pld_q[0] <= cmd_pld_i;
                end
                default: ;
            endcase
        end else if (state_q == StSiftUp && up_swap) begin
            key_q[idx_q]      <= key_q[parent_idx];
            pld_q[idx_q]      <= pld_q[parent_idx];
            key_q[parent_idx] <= key_q[idx_q];
            pld_q[parent_idx] <= pld_q[idx_q];
        end else if (state_q == StSiftDown && down_swap) begin
            key_q[idx_q]    <= key_q[best_idx];
            pld_q[idx_q]    <= pld_q[best_idx];
            key_q[best_idx] <= key_q[idx_q];
            pld_q[best_idx] <= pld_q[idx_q];
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign rsp_valid_o  = (state_q == StDone);
    assign rsp_status_o = rsp_status_q;
    assign rsp_key_o    = rsp_key_q;
    assign rsp_pld_o    = rsp_pld_q;
    assign count_o      = count_q;
    assign top_valid_o  = !empty && (state_q == StIdle);
    assign top_key_o    = top_valid_o ? key_q[0] : '0;

endmodule

// File: tb/tb_heap_pq.sv
// Self-checking bench for heap_pq: directed scenarios plus randomized traffic on a max-heap
// (1024 entries) and a min-heap (4 entries) against a queue-based priority model.
module tb_heap_pq;
    import heap_pkg::*;

    localparam int unsigned KW = 32;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid  [2];
    logic [1:0]    cmd_op     [2];
    logic [KW-1:0] cmd_key    [2];
    logic [PW-1:0] cmd_pld    [2];
    logic          cmd_ready  [2];
    logic          rsp_valid  [2];
    logic [1:0]    rsp_status [2];
    logic [KW-1:0] rsp_key    [2];
    logic [PW-1:0] rsp_pld    [2];
    logic          top_valid  [2];
    logic [KW-1:0] top_key    [2];
    logic [10:0]   count0;
    logic [2:0]    count1;

    heap_pq #(.KEY_W(KW), .PLD_W(PW), .DEPTH_LOG2(10), .MIN_HEAP(0)) u_max (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_op_i(cmd_op[0]),
        .cmd_key_i(cmd_key[0]), .cmd_pld_i(cmd_pld[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_status_o(rsp_status[0]), .rsp_key_o(rsp_key[0]),
        .rsp_pld_o(rsp_pld[0]), .count_o(count0), .top_valid_o(top_valid[0]),
        .top_key_o(top_key[0])
    );

    heap_pq #(.KEY_W(KW), .PLD_W(PW), .DEPTH_LOG2(2), .MIN_HEAP(1)) u_min (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_op_i(cmd_op[1]),
        .cmd_key_i(cmd_key[1]), .cmd_pld_i(cmd_pld[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_status_o(rsp_status[1]), .rsp_key_o(rsp_key[1]),
        .rsp_pld_o(rsp_pld[1]), .count_o(count1), .top_valid_o(top_valid[1]),
        .top_key_o(top_key[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt(input int d);
        return (d == 0) ? int'(count0) : int'(count1);
    endfunction

    function automatic int ilog2(input int n);
        int r = 0;
        while (n > 1) begin
            n = n >> 1;
            r++;
        end
        return r;
    endfunction

    task automatic do_cmd(input int d, input logic [1:0] op, input logic [KW-1:0] key,
                          input logic [PW-1:0] pld, output logic [1:0] st,
                          output logic [KW-1:0] k, output logic [PW-1:0] p, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready[d] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready[d]) check_eq("ready_timeout", 0, 1);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_key[d]   = key;
        cmd_pld[d]   = pld;
        @(posedge clk);
        #1 cmd_valid[d] = 1'b0;
        st  = 2'b11;
        k   = '0;
        p   = '0;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[d]) break;
        end
        if (!rsp_valid[d]) check_eq("rsp_timeout", lat, 0);
        else begin
            st = rsp_status[d];
            k  = rsp_key[d];
            p  = rsp_pld[d];
        end
    endtask

    // One directed command; exp_lat < 0 skips the latency check.
    task automatic run(input int d, input logic [1:0] op, input int key, input logic [1:0] exp_st,
                       input int exp_key, input int exp_pld, input int exp_lat, input string tag);
        logic [1:0]    st;
        logic [KW-1:0] k;
        logic [PW-1:0] p;
        int            lat;
        do_cmd(d, op, KW'(key), PW'(key), st, k, p, lat);
        check_eq({tag, "_st"}, st, exp_st);
        check_eq({tag, "_key"}, k, exp_key);
        check_eq({tag, "_pld"}, p, exp_pld);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic check_top(input int d, input int exp_cnt, input int exp_top, input string tag);
        @(negedge clk);
        check_eq({tag, "_count"}, cnt(d), exp_cnt);
        check_eq({tag, "_topv"}, top_valid[d], (exp_cnt != 0) ? 1 : 0);
        check_eq({tag, "_topk"}, top_key[d], exp_top);
    endtask

    typedef struct packed {
        logic [KW-1:0] k;
        logic [PW-1:0] p;
    } ent_t;

    ent_t mq[$];

    function automatic int best_ix(input bit mn);
        int b = -1;
        foreach (mq[i]) begin
            if (b < 0 || (mn ? (mq[i].k < mq[b].k) : (mq[i].k > mq[b].k))) b = i;
        end
        return b;
    endfunction

    task automatic rand_run(input int d, input bit mn, input int cap, input int nops);
        logic [1:0]    op, st, exp_st;
        logic [KW-1:0] key, k;
        logic [PW-1:0] pld, p;
        int            lat, r, b, j;
        ent_t          e;
        mq.delete();
        for (int n = 0; n < nops; n++) begin
            r   = $urandom_range(0, 9);
            op  = (r == 0) ? OpNop : (r <= 4) ? OpPush : (r <= 7) ? OpPop : OpRepl;
            key = KW'($urandom_range(0, 15));
            pld = PW'($urandom);
            e.k = key;
            e.p = pld;
            do_cmd(d, op, key, pld, st, k, p, lat);
            if (op == OpNop) begin
                check_eq("rnd_nop_st", st, StatOk);
                check_eq("rnd_nop_key", k, 0);
            end else if (op == OpPush) begin
                exp_st = (mq.size() == cap) ? StatFull : StatOk;
                check_eq("rnd_push_st", st, exp_st);
                if (exp_st == StatOk) mq.push_back(e);
            end else if (mq.size() == 0) begin
                check_eq("rnd_empty_st", st, StatEmpty);
                check_eq("rnd_empty_key", k, 0);
                if (op == OpRepl) mq.push_back(e);
            end else begin
                b = best_ix(mn);
                check_eq("rnd_pop_st", st, StatOk);
                check_eq("rnd_pop_key", k, mq[b].k);
                j = -1;
                foreach (mq[i]) if (j < 0 && mq[i].k == k && mq[i].p == p) j = i;
                check_eq("rnd_pop_pld_known", (j >= 0) ? 1 : 0, 1);
                mq.delete((j >= 0) ? j : b);
                if (op == OpRepl) mq.push_back(e);
            end
            b = best_ix(mn);
            check_top(d, mq.size(), (b >= 0) ? int'(mq[b].k) : 0, "rnd");
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    st;
        logic [KW-1:0] k;
        logic [PW-1:0] p;
        int            lat, seen;

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_op[d]    = OpNop;
            cmd_key[d]   = '0;
            cmd_pld[d]   = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ready", cmd_ready[0], 1);
        check_eq("rst_rspv", rsp_valid[0], 0);
        check_eq("rst_status", rsp_status[0], 0);
        check_eq("rst_rkey", rsp_key[0], 0);
        check_eq("rst_count", cnt(0), 0);
        check_eq("rst_topv", top_valid[0], 0);
        check_eq("rst_topk", top_key[0], 0);
        rst_n = 1'b1;

        // Max-heap basics.
        run(0, OpPush, 5, StatOk, 0, 0, 2, "p5");
        run(0, OpPush, 9, StatOk, 0, 0, 3, "p9");
        run(0, OpPush, 3, StatOk, 0, 0, 2, "p3");
        check_top(0, 3, 9, "after3");
        run(0, OpPop, 0, StatOk, 9, 9, -1, "pop9");
        run(0, OpPop, 0, StatOk, 5, 5, -1, "pop5");
        run(0, OpPop, 0, StatOk, 3, 3, -1, "pop3");
        run(0, OpPop, 0, StatEmpty, 0, 0, 1, "pop_empty");
        run(0, OpNop, 0, StatOk, 0, 0, 1, "nop");
        check_top(0, 0, 0, "nop");

        // Min-heap, 4 entries: full boundary.
        run(1, OpPush, 7, StatOk, 0, 0, 2, "m7");
        run(1, OpPush, 2, StatOk, 0, 0, 3, "m2");
        run(1, OpPush, 9, StatOk, 0, 0, 2, "m9");
        run(1, OpPush, 4, StatOk, 0, 0, 3, "m4");
        check_top(1, 4, 2, "m_full");
        run(1, OpPush, 1, StatFull, 0, 0, 1, "m_push_full");
        check_top(1, 4, 2, "m_after_full");
        run(1, OpPop, 0, StatOk, 2, 2, -1, "mpop2");
        run(1, OpPop, 0, StatOk, 4, 4, -1, "mpop4");
        run(1, OpPop, 0, StatOk, 7, 7, -1, "mpop7");
        run(1, OpPop, 0, StatOk, 9, 9, -1, "mpop9");

        // Replace.
        run(0, OpPush, 8, StatOk, 0, 0, -1, "r8");
        run(0, OpPush, 6, StatOk, 0, 0, -1, "r6");
        run(0, OpPush, 5, StatOk, 0, 0, -1, "r5");
        run(0, OpRepl, 1, StatOk, 8, 8, -1, "repl1");
        check_top(0, 3, 6, "repl1");
        run(0, OpPop, 0, StatOk, 6, 6, -1, "rpop6");
        run(0, OpPop, 0, StatOk, 5, 5, -1, "rpop5");
        run(0, OpPop, 0, StatOk, 1, 1, -1, "rpop1");
        run(0, OpRepl, 4, StatEmpty, 0, 0, 2, "repl_empty");
        check_top(0, 1, 4, "repl_empty");
        run(0, OpPop, 0, StatOk, 4, 4, -1, "rpop4");

        // Ascending fill: every push rises to the root.
        for (int n = 1; n <= 1024; n++) begin
            do_cmd(0, OpPush, KW'(n), PW'(n), st, k, p, lat);
            check_eq($sformatf("asc_st%0d", n), st, StatOk);
            check_eq($sformatf("asc_lat%0d", n), lat, 2 + ilog2(n));
            @(negedge clk);
            check_eq($sformatf("asc_top%0d", n), top_key[0], n);
        end
        check_eq("asc_count", cnt(0), 1024);
        run(0, OpPush, 7, StatFull, 0, 0, 1, "asc_full");
        for (int n = 1024; n >= 1; n--) begin
            do_cmd(0, OpPop, '0, '0, st, k, p, lat);
            check_eq($sformatf("drain_st%0d", n), st, StatOk);
            check_eq($sformatf("drain_key%0d", n), k, n);
            check_eq($sformatf("drain_pld%0d", n), p, n % 256);
        end
        check_top(0, 0, 0, "drained");

        // Reset during SIFT_DOWN.
        for (int n = 1; n <= 5; n++) run(0, OpPush, n * 10, StatOk, 0, 0, -1, "pre_rst");
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OpPop;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        seen = 0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        check_eq("rst_mid_rsp", seen, 0);
        check_eq("rst_mid_count", cnt(0), 0);
        check_eq("rst_mid_ready", cmd_ready[0], 1);
        run(0, OpPush, 3, StatOk, 0, 0, 2, "post_rst");
        check_top(0, 1, 3, "post_rst");
        run(0, OpPop, 0, StatOk, 3, 3, -1, "post_rst_pop");

        rand_run(0, 1'b0, 1024, 1500);
        rand_run(1, 1'b1, 4, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
